snoop_responder: RTL and testbench

Snoop-side responder for one L2 cache: the other end of the GetSnoopResult/bus-operation protocol the cache uses as initiator. It accepts bus operations snooped from other processors and scans the 8 ways of the addressed set through the tag/MESI array port. It returns HIT/HITM/NOHIT, pushes modified lines out via a writeback handshake, and applies the snooped MESI transition. It sits between the system-bus snoop interface and the L2 tag/MESI array.

---
 rtl/snoop_responder_pkg.sv | 35 +++
 rtl/snoop_mesi_table.sv | 41 ++++
 rtl/snoop_responder.sv | 120 ++++++++++++
 tb/tb_snoop_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_responder_pkg.sv
// rtl/snoop_responder_pkg.sv - shared sizes and encodings for the L2 snoop responder
package snoop_responder_pkg;

  localparam int WAYS     = 8;
  localparam int WAY_W    = 3;
  localparam int TAG_W    = 12;
  localparam int INDEX_W  = 14;
  localparam int OFFSET_W = 6;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_READ       = 3'd1,
    OP_WRITE      = 3'd2,
    OP_INVALIDATE = 3'd3,
    OP_RWIM       = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    RES_HIT   = 2'b00,
    RES_HITM  = 2'b01,
    RES_NOHIT = 2'b10
  } snoop_res_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage

// File: rtl/snoop_mesi_table.sv
// rtl/snoop_mesi_table.sv - snoop result, next MESI state, writeback need and error decode
module snoop_mesi_table
  import snoop_responder_pkg::*;
(
  input  bus_op_t    op,
  input  logic       hit,
  input  mesi_t      mesi,
  output snoop_res_t result,
  output mesi_t      next_mesi,
  output logic       need_wb,
  output logic       error
);

  always_comb begin
    result    = RES_NOHIT;
    next_mesi = mesi;
    need_wb   = 1'b0;
    error     = 1'b0;
    if (hit) begin
      result = (mesi == MESI_M) ? RES_HITM : RES_HIT;
      case (op)
        OP_READ: begin
          next_mesi = MESI_S;
          need_wb   = (mesi == MESI_M);
        end
        OP_RWIM: begin
          next_mesi = MESI_I;
          need_wb   = (mesi == MESI_M);
        end
        // Another agent invalidating a line we own exclusively is a coherence bug.
        OP_INVALIDATE: begin
          if (mesi == MESI_S) next_mesi = MESI_I;
          else                error     = 1'b1;
        end
        OP_WRITE: error = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - snoop-side responder scanning one L2 set and applying MESI transitions
module snoop_responder
  import snoop_responder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               snoop_valid,
  output logic               snoop_ready,
  input  logic [2:0]         snoop_op,
  input  logic [31:0]        snoop_addr,
  output logic [INDEX_W-1:0] arr_index,
  output logic [WAY_W-1:0]   arr_way,
  input  logic [TAG_W-1:0]   arr_rd_tag,
  input  logic [1:0]         arr_rd_mesi,
  output logic               arr_wr_en,
  output logic [1:0]         arr_wr_mesi,
  output logic               result_valid,
  output logic [1:0]         result,
  output logic [WAY_W-1:0]   result_way,
  output logic               wb_req,
  output logic [31:0]        wb_addr,
  input  logic               wb_ack,
  output logic               protocol_error
);

  typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_RESP, ST_WB, ST_UPDATE} state_t;

  state_t             state, state_nx;
  logic [WAY_W-1:0]   way_cnt, way_q;
  bus_op_t            op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic               hit_q;
  mesi_t              mesi_q;

  logic       accept, scan_hit, last_way;
  snoop_res_t tbl_result;
  mesi_t      tbl_next;
  logic       tbl_wb, tbl_err;
  logic       unused_offset;

  assign unused_offset = ^snoop_addr[OFFSET_W-1:0];
  assign accept   = snoop_valid && (state == ST_IDLE) && op_is_legal(snoop_op);
  assign scan_hit = (arr_rd_mesi != MESI_I) && (arr_rd_tag == tag_q);
  assign last_way = (way_cnt == WAY_W'(WAYS - 1));

  snoop_mesi_table u_table (
    .op        (op_q),
    .hit       (hit_q),
    .mesi      (mesi_q),
    .result    (tbl_result),
    .next_mesi (tbl_next),
    .need_wb   (tbl_wb),
    .error     (tbl_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      way_cnt <= '0;
      way_q   <= '0;
      op_q    <= OP_NONE;
      tag_q   <= '0;
      index_q <= '0;
      hit_q   <= 1'b0;
      mesi_q  <= MESI_I;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= bus_op_t'(snoop_op);
            tag_q   <= snoop_addr[31 -: TAG_W];
            index_q <= snoop_addr[OFFSET_W +: INDEX_W];
            way_cnt <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
            mesi_q  <= MESI_I;
          end
        end
        // Ways are probed in ascending order, so the first match is the lowest way.
        ST_SCAN: begin
          if (scan_hit) begin
            hit_q  <= 1'b1;
            way_q  <= way_cnt;
            mesi_q <= mesi_t'(arr_rd_mesi);
          end else if (!last_way) begin
            way_cnt <= way_cnt + WAY_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_SCAN;
      ST_SCAN:   if (scan_hit || last_way) state_nx = ST_RESP;
      ST_RESP:   state_nx = tbl_wb ? ST_WB : ST_UPDATE;
      ST_WB:     if (wb_ack) state_nx = ST_UPDATE;
      ST_UPDATE: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign snoop_ready    = (state == ST_IDLE);
  assign arr_index      = index_q;
  assign arr_way        = (state == ST_UPDATE) ? way_q : way_cnt;
  assign result_valid   = (state == ST_RESP);
  assign result         = (state == ST_RESP) ? tbl_result : 2'b00;
  assign result_way     = ((state == ST_RESP) && hit_q) ? way_q : '0;
  assign wb_req         = (state == ST_WB);
  assign wb_addr        = (state == ST_WB) ? {tag_q, index_q, {OFFSET_W{1'b0}}} : 32'h0;
  assign arr_wr_en      = (state == ST_UPDATE) && hit_q && (tbl_next != mesi_q);
  assign arr_wr_mesi    = arr_wr_en ? tbl_next : 2'b00;
  assign protocol_error = (state == ST_UPDATE) && tbl_err;

endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - directed self-checking bench for snoop_responder
module tb_snoop_responder;
  import snoop_responder_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               snoop_valid = 1'b0;
  logic               snoop_ready;
  logic [2:0]         snoop_op = 3'd0;
  logic [31:0]        snoop_addr = 32'h0;
  logic [INDEX_W-1:0] arr_index;
  logic [WAY_W-1:0]   arr_way;
  logic [TAG_W-1:0]   arr_rd_tag;
  logic [1:0]         arr_rd_mesi;
  logic               arr_wr_en;
  logic [1:0]         arr_wr_mesi;
  logic               result_valid;
  logic [1:0]         result;
  logic [WAY_W-1:0]   result_way;
  logic               wb_req;
  logic [31:0]        wb_addr;
  logic               wb_ack = 1'b0;
  logic               protocol_error;

  int n_cmp = 0;
  int n_bad = 0;

  // Small array model: four sets by eight ways.
  logic [TAG_W-1:0] mtag  [0:3][0:7];
  logic [1:0]       mmesi [0:3][0:7];

  // Per-transaction observations.
  int          res_cyc, ready_cyc, wr_count, perr_count;
  logic [1:0]  res_val, wr_mesi;
  logic [2:0]  res_way, wr_way;
  logic        wb_seen;
  logic [31:0] wb_addr_seen;

  always #5 clk = ~clk;

  snoop_responder dut (
    .clk            (clk),
    .rst            (rst),
    .snoop_valid    (snoop_valid),
    .snoop_ready    (snoop_ready),
    .snoop_op       (snoop_op),
    .snoop_addr     (snoop_addr),
    .arr_index      (arr_index),
    .arr_way        (arr_way),
    .arr_rd_tag     (arr_rd_tag),
    .arr_rd_mesi    (arr_rd_mesi),
    .arr_wr_en      (arr_wr_en),
    .arr_wr_mesi    (arr_wr_mesi),
    .result_valid   (result_valid),
    .result         (result),
    .result_way     (result_way),
    .wb_req         (wb_req),
    .wb_addr        (wb_addr),
    .wb_ack         (wb_ack),
    .protocol_error (protocol_error)
  );

  assign arr_rd_tag  = mtag[arr_index[1:0]][arr_way];
  assign arr_rd_mesi = mmesi[arr_index[1:0]][arr_way];

  always @(posedge clk)
    if (arr_wr_en) mmesi[arr_index[1:0]][arr_way] <= arr_wr_mesi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_array();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 8; w++) begin
        mtag[s][w]  = '0;
        mmesi[s][w] = MESI_I;
      end
  endtask

  task automatic handshake(input logic [2:0] op, input logic [31:0] addr);
    @(negedge clk);
    snoop_valid = 1'b1;
    snoop_op    = op;
    snoop_addr  = addr;
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
  endtask

  // Issue one snoop and watch it until the responder returns to IDLE.
  task automatic run_snoop(input logic [2:0] op, input logic [31:0] addr, input int wb_delay);
    int wbcnt;
    res_cyc = 0; ready_cyc = 0; wr_count = 0; perr_count = 0;
    res_val = 2'b11; res_way = 3'd0; wr_mesi = 2'b00; wr_way = 3'd0;
    wb_seen = 1'b0; wb_addr_seen = 32'h0; wbcnt = 0;
    handshake(op, addr);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (result_valid) begin
        res_cyc = i; res_val = result; res_way = result_way;
      end
      if (arr_wr_en) begin
        wr_count++; wr_mesi = arr_wr_mesi; wr_way = arr_way;
      end
      if (protocol_error) perr_count++;
      if (wb_req) begin
        wb_seen = 1'b1; wb_addr_seen = wb_addr; wbcnt++;
        if (wbcnt == wb_delay) wb_ack = 1'b1;
      end else begin
        wb_ack = 1'b0;
      end
      if (snoop_ready) begin
        ready_cyc = i;
        break;
      end
    end
    wb_ack = 1'b0;
  endtask

  initial begin
    int wr_after, rv_seen, nrdy;
    clear_array();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", snoop_ready, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_wb_req", wb_req, 0);
    chk("rst_arr_wr_en", arr_wr_en, 0);
    chk("rst_perr", protocol_error, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    // READ hit in way 3, shared: no writeback, no array write
    mtag[0][3] = 12'h111; mmesi[0][3] = MESI_S;
    run_snoop(3'd1, 32'h1110_0000, 0);
    chk("rd_s_res_cyc", res_cyc, 5);
    chk("rd_s_result", res_val, RES_HIT);
    chk("rd_s_way", res_way, 3);
    chk("rd_s_wr", wr_count, 0);
    chk("rd_s_wb", wb_seen, 0);
    chk("rd_s_ready", ready_cyc, 7);

    // READ hit on modified way 0: writeback then M->S
    mtag[1][0] = 12'h222; mmesi[1][0] = MESI_M;
    run_snoop(3'd1, 32'h2220_0040, 4);
    chk("rd_m_res_cyc", res_cyc, 2);
    chk("rd_m_result", res_val, RES_HITM);
    chk("rd_m_way", res_way, 0);
    chk("rd_m_wb", wb_seen, 1);
    chk("rd_m_wb_addr", wb_addr_seen, 32'h2220_0040);
    chk("rd_m_wr", wr_count, 1);
    chk("rd_m_wr_mesi", wr_mesi, MESI_S);
    chk("rd_m_wr_way", wr_way, 0);
    chk("rd_m_ready", ready_cyc, 8);
    chk("rd_m_array", mmesi[1][0], MESI_S);

    // Miss: all ways invalid, a stale matching tag must not hit
    mtag[2][4] = 12'h333;
    run_snoop(3'd1, 32'h3330_0080, 0);
    chk("miss_res_cyc", res_cyc, 9);
    chk("miss_result", res_val, RES_NOHIT);
    chk("miss_way", res_way, 0);
    chk("miss_wb", wb_seen, 0);
    chk("miss_wr", wr_count, 0);
    chk("miss_ready", ready_cyc, 11);

    // RWIM on exclusive way 7
    mtag[3][7] = 12'h444; mmesi[3][7] = MESI_E;
    run_snoop(3'd4, 32'h4440_00C0, 0);
    chk("rwim_e_res_cyc", res_cyc, 9);
    chk("rwim_e_result", res_val, RES_HIT);
    chk("rwim_e_way", res_way, 7);
    chk("rwim_e_wr_mesi", wr_mesi, MESI_I);
    chk("rwim_e_wr_way", wr_way, 7);
    chk("rwim_e_ready", ready_cyc, 11);

    // RWIM on modified way 5: writeback then invalidate
    mtag[3][5] = 12'h444; mmesi[3][5] = MESI_M;
    run_snoop(3'd4, 32'h4440_00C0, 1);
    chk("rwim_m_res_cyc", res_cyc, 7);
    chk("rwim_m_result", res_val, RES_HITM);
    chk("rwim_m_wb_addr", wb_addr_seen, 32'h4440_00C0);
    chk("rwim_m_wr_mesi", wr_mesi, MESI_I);
    chk("rwim_m_wr_way", wr_way, 5);
    chk("rwim_m_ready", ready_cyc, 10);
    chk("rwim_m_array", mmesi[3][5], MESI_I);

    // INVALIDATE on a modified line is illegal
    mmesi[1][0] = MESI_M;
    run_snoop(3'd3, 32'h2220_0040, 0);
    chk("inv_m_result", res_val, RES_HITM);
    chk("inv_m_perr", perr_count, 1);
    chk("inv_m_wr", wr_count, 0);
    chk("inv_m_wb", wb_seen, 0);
    chk("inv_m_ready", ready_cyc, 4);
    chk("inv_m_array", mmesi[1][0], MESI_M);

    // WRITE hitting a shared line is illegal
    run_snoop(3'd2, 32'h1110_0000, 0);
    chk("wr_s_result", res_val, RES_HIT);
    chk("wr_s_perr", perr_count, 1);
    chk("wr_s_wr", wr_count, 0);
    chk("wr_s_ready", ready_cyc, 7);
    chk("wr_s_array", mmesi[0][3], MESI_S);

    // Reserved op code is not accepted
    handshake(3'd5, 32'h1110_0000);
    rv_seen = 0; nrdy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
      if (!snoop_ready) nrdy++;
    end
    chk("op5_no_result", rv_seen, 0);
    chk("op5_stays_ready", nrdy, 0);

    // Reset while a writeback is pending
    mmesi[1][0] = MESI_M;
    handshake(3'd1, 32'h2220_0040);
    for (int i = 0; i < 20 && !wb_req; i++) @(negedge clk);
    chk("rst_wb_reached", wb_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_wb_req", wb_req, 0);
    chk("rst_mid_ready", snoop_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    wr_after = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (arr_wr_en) wr_after++;
    end
    chk("rst_mid_no_wr", wr_after, 0);
    chk("rst_mid_array", mmesi[1][0], MESI_M);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
